id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of the register file.
//  - Captures ReadData1/ReadData2, the decoded immediate, register fields, PC+4 and the control bundle.
//  - Detects load-use hazards and inserts one bubble.
//  - Honours downstream stall and branch/jump flush.
//  - Feeds the EX stage and the forwarding unit.
// PARAMETERS
//  DATA_W  32  datapath width
//  CTRL_W  8   control bundle {RegDst,ALUSrc,MemRead,MemWrite,MemToReg,RegWrite,ALUOp[1:0]}
//  CNT_W   16  width of bubble performance counter
// PORTS
//  clk            in   1       rising-edge clock, sole clock domain
//  rst_n          in   1       asynchronous, active-low reset
//  id_valid       in   1       IF/ID holds a valid instruction
//  id_instr       in   32      instruction word in ID
//  id_pc4         in   32      PC+4 of instruction in ID
//  id_ctrl        in   CTRL_W  control bundle from main decoder
//  ReadData1      in   DATA_W  register file port 1 (rs)
//  ReadData2      in   DATA_W  register file port 2 (rt)
//  wb_reg_write   in   1       WB write enable (same net as register file write enable)
//  wb_write_reg   in   5       WB destination register
//  wb_write_data  in   DATA_W  WB data
//  flush          in   1       kill ID instruction (taken branch/jump)
//  ex_stall       in   1       EX/MEM cannot accept; hold this stage
//  id_stall       out  1       hold PC and IF/ID (combinational)
//  ex_valid       out  1       EX slot holds a real instruction
//  ex_ctrl        out  CTRL_W  control to EX (all zero when !ex_valid)
//  ex_rs_data     out  DATA_W  rs operand
//  ex_rt_data     out  DATA_W  rt operand
//  ex_imm         out  DATA_W  extended immediate
//  ex_rs          out  5       rs index, instr[25:21]
//  ex_rt          out  5       rt index, instr[20:16]
//  ex_rd          out  5       rd index, instr[15:11]
//  ex_pc4         out  32      PC+4
//  bubble_cnt     out  CNT_W   saturating count of inserted load-use bubbles
// BEHAVIOUR
//  - Reset (async, rst_n=0): every registered output -> 0; ex_valid=0; bubble_cnt=0.
//  - Latency: one cycle from ID inputs to ex_* outputs.
//  - hazard = id_valid & ex_valid & ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==instr[25:21] | ex_rt==instr[20:16]).
//  - id_stall = hazard | ex_stall (combinational).
//  - Per-edge priority:
//    flush   -> bubble: ex_valid=0, ex_ctrl=0, data fields don't-care but driven 0
//    ex_stall-> hold all ex_* registers
//    hazard  -> bubble; bubble_cnt+1, saturating at all-ones
//    else    -> load; ex_valid=id_valid, ex_ctrl=id_valid?id_ctrl:0
//  - flush + ex_stall in the same cycle: flush wins.
//  - flush + hazard in the same cycle: bubble, bubble_cnt unchanged.
//  - Hazard clears after exactly one bubble, because ex_valid=0 the next cycle.
//  - Immediate: zero-extend instr[15:0] for opcode 0x0C/0x0D/0x0E (andi/ori/xori); sign-extend otherwise.
//  - Register $0 never flags a hazard and never bypasses.
// CONFIGURATION
//  ID_EX_WB_BYPASS_EN defined:
//   - On load, if wb_reg_write & wb_write_reg!=0 & wb_write_reg==rs (resp. rt), capture wb_write_data instead of ReadData1 (resp. ReadData2).
//   - While held by ex_stall, a matching WB write refreshes ex_rs_data/ex_rt_data.
//  ID_EX_WB_BYPASS_EN undefined:
//   - Operands are captured from ReadData1/2 unmodified.
//   - Held operands never change during a hold.
// STRUCTURE
//  - mips_pkg holds: DATA_W, CTRL_W, control-bit index localparams (CTRL_MEMREAD etc.), opcode constants OP_ANDI/OP_ORI/OP_XORI.
//  - Sub-module mips_hazard_unit: combinational load-use compare producing hazard.
//  - Top level: pipeline registers, bypass mux, immediate extension, counter.
// TESTING
//  - Reset mid-run: rst_n low for 3ns off-edge -> all ex_* and bubble_cnt read 0 immediately.
//  - Plain load: add $3,$1,$2 with ReadData1=4, ReadData2=1048580 -> next cycle ex_valid=1, ex_rs_data=4, ex_rt_data=1048580, ex_rd=3.
//  - Load-use: lw $4,0($1) in EX, then add $5,$4,$2 in ID -> id_stall=1 one cycle, ex_valid=0, bubble_cnt=1; the add loads on the following cycle.
//  - Stall vs flush: ex_stall=1 for 2 cycles -> ex_* frozen; flush with ex_stall=1 -> ex_valid=0 next edge.
//  - Immediate: ori imm 0xFFFF -> ex_imm=0x0000FFFF; addi imm 0xFFFF -> ex_imm=0xFFFFFFFF.
//  - Bypass (ID_EX_WB_BYPASS_EN): WB writes $2=0xDEADBEEF while ReadData2 is stale 7 -> ex_rt_data=0xDEADBEEF; without the macro -> 7.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control-bit indices and opcodes for the ID/EX slice
//
// Purpose : constants and helpers used by id_ex_stage_reg and mips_hazard_unit.
// Ports   : none (package).
// Control bundle layout (MSB..LSB):
//   {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ALUOp[1:0]}
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_REGWRITE = 2;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  // Logical immediates are unsigned; every other I-type immediate is signed.
  function automatic logic is_zext_op(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// rtl/mips_hazard_unit.sv - combinational load-use hazard detector
//
// Purpose : flags when the instruction in ID reads the destination of a load
//           currently sitting in EX, so one bubble must be inserted.
// Ports   :
//   id_valid    in  1  ID holds a real instruction
//   id_rs/id_rt in  5  source register indices of the ID instruction
//   ex_valid    in  1  EX holds a real instruction
//   ex_mem_read in  1  EX instruction is a load
//   ex_rt       in  5  load destination register
//   hazard      out 1  insert a bubble this cycle
module mips_hazard_unit (
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble, stall and flush
//
// Purpose : captures operands, immediate, register fields, PC+4 and control for EX;
//           inserts one bubble on a load-use hazard and counts bubbles.
// Option  : ID_EX_WB_BYPASS_EN - forward a same-cycle WB write into captured/held operands.
// Ports   :
//   clk, rst_n                     clock, async active-low reset
//   id_valid/id_instr/id_pc4/id_ctrl  instruction in ID and its decoded control
//   ReadData1/ReadData2            register file read ports (rs/rt)
//   wb_reg_write/wb_write_reg/wb_write_data  WB write port
//   flush, ex_stall                kill ID instruction / hold this stage
//   id_stall                       hold PC and IF/ID (combinational)
//   ex_valid/ex_ctrl/ex_rs_data/ex_rt_data/ex_imm/ex_rs/ex_rt/ex_rd/ex_pc4  EX stage fields
//   bubble_cnt                     saturating count of load-use bubbles
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [31:0]       r_pc4;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_hazard;
  logic              w_bubble;
  logic [4:0]        w_id_rs;
  logic [4:0]        w_id_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_hold_rs_data;
  logic [DATA_W-1:0] w_hold_rt_data;

  assign w_id_rs = id_instr[25:21];
  assign w_id_rt = id_instr[20:16];

  mips_hazard_unit u_hazard (
    .id_valid    (id_valid),
    .id_rs       (w_id_rs),
    .id_rt       (w_id_rt),
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl[CTRL_MEMREAD]),
    .ex_rt       (r_rt),
    .hazard      (w_hazard)
  );

  assign id_stall = w_hazard | ex_stall;

  // Flush beats stall; a hazard only bubbles when the stage is free to advance.
  assign w_bubble = flush | (~ex_stall & w_hazard);

  assign w_imm = is_zext_op(id_instr[31:26]) ?
                 {{(DATA_W-16){1'b0}}, id_instr[15:0]} :
                 {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

`ifdef ID_EX_WB_BYPASS_EN
  logic w_wb_live;
  assign w_wb_live      = wb_reg_write & (wb_write_reg != 5'd0);
  assign w_rs_data      = (w_wb_live && wb_write_reg == w_id_rs) ? wb_write_data : ReadData1;
  assign w_rt_data      = (w_wb_live && wb_write_reg == w_id_rt) ? wb_write_data : ReadData2;
  // A write landing while we are frozen would otherwise be lost to this instruction.
  assign w_hold_rs_data = (w_wb_live && wb_write_reg == r_rs) ? wb_write_data : r_rs_data;
  assign w_hold_rt_data = (w_wb_live && wb_write_reg == r_rt) ? wb_write_data : r_rt_data;
`else
  logic w_unused_wb;
  assign w_unused_wb    = ^{wb_reg_write, wb_write_reg, wb_write_data};
  assign w_rs_data      = ReadData1;
  assign w_rt_data      = ReadData2;
  assign w_hold_rs_data = r_rs_data;
  assign w_hold_rt_data = r_rt_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_pc4        <= '0;
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_pc4     <= '0;
      // Only genuine load-use bubbles are counted, not flush-induced ones.
      if (!flush && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else if (ex_stall) begin
      r_rs_data <= w_hold_rs_data;
      r_rt_data <= w_hold_rt_data;
    end else begin
      r_valid   <= id_valid;
      r_ctrl    <= id_valid ? id_ctrl : '0;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= w_imm;
      r_rs      <= w_id_rs;
      r_rt      <= w_id_rt;
      r_rd      <= id_instr[15:11];
      r_pc4     <= id_pc4;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_ctrl    = r_ctrl;
  assign ex_rs_data = r_rs_data;
  assign ex_rt_data = r_rt_data;
  assign ex_imm     = r_imm;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_pc4     = r_pc4;
  assign bubble_cnt = r_bubble_cnt;

endmodule
